conv_out_collector: RTL and testbench
=====================================

// Module: conv_out_collector
// PURPOSE
//  Downstream stage of the 3x3 multiply/add-tree window unit. Accepts one signed window
//  sum per handshake in raster order (row-major over output positions) and assembles a
//  full output feature map. Presents the packed map with a valid/ready handshake.
//  Back-pressures the window unit while a completed map waits to be consumed.
// PARAMETERS
//  filter_demension  3   kernel edge length
//  stride            1   window step
//  input_demension   5   input image edge length
//  sum_width         12  width of one signed window sum (matches add-tree output)
//  localparam out_demension = (input_demension-filter_demension)/stride+1  (3 by default)
//  localparam out_size      = out_demension*out_demension                  (9 by default)
// PORTS
//  clk        in   1                   rising-edge clock
//  rst        in   1                   synchronous, active-high reset
//  in_valid   in   1                   in_sum carries a valid window sum
//  in_ready   out  1                   collector can accept in_sum this cycle
//  in_sum     in   sum_width           signed window sum, two's complement
//  out_valid  out  1                   out_map holds a complete feature map
//  out_ready  in   1                   consumer takes out_map this cycle
//  out_map    out  out_size*sum_width  element k at [(k+1)*sum_width-1 : k*sum_width], k=row*out_demension+col
//  out_row    out  8                   row index of next element to be written
//  out_col    out  8                   col index of next element to be written
//  frame_cnt  out  8                   number of maps delivered, wraps 255->0
// BEHAVIOUR
//  - States: FILL, HOLD. Reset -> FILL; out_valid=0, out_map=0, out_row=0, out_col=0, frame_cnt=0.
//  - in_ready = (state==FILL) (combinational from state only; no dependence on out_ready).
//  - Accept = in_valid & in_ready. On accept: element [out_row*out_demension+out_col] <= in_sum
//    (after optional ReLU); out_col++; at out_col==out_demension-1 -> out_col=0, out_row++.
//  - Accepting element out_size-1: counters return to 0, state -> HOLD, out_valid=1 next cycle.
//  - Latency: last sum accepted at cycle N -> out_valid high at N+1, map includes that sum.
//  - HOLD: out_map and counters frozen; in_ready=0; in_sum ignored even if in_valid=1.
//  - HOLD & out_ready: out_valid=0 next cycle, state -> FILL, frame_cnt++ (wraps).
//    in_ready is 0 in the handshake cycle; first new sum accepted no earlier than the next cycle.
//  - out_ready while out_valid=0: no effect.
//  - Stale elements: out_map is not cleared between frames; every element is overwritten
//    before the next out_valid, so no stale data is ever presented.
//  - in_valid gaps in FILL: counters hold, no write.
//  - rst mid-frame or in HOLD: partial map discarded, all outputs to reset values next cycle.
//  - No arithmetic besides optional clamp; sum width preserved bit-exact.
// CONFIGURATION
//  - CONV_OUT_RELU_EN defined: stored element = (in_sum[sum_width-1]) ? 0 : in_sum.
//  - CONV_OUT_RELU_EN undefined: stored element = in_sum unchanged (negatives kept).
//  - Handshake, timing and counters identical in both builds.
// TESTING
//  1 rst high 2 cycles -> out_valid=0, in_ready=1, out_map=0, out_row=out_col=0, frame_cnt=0.
//  2 feed sums 1..9 back-to-back, out_ready=0 -> out_valid 1 cycle after 9th; element k = k+1;
//    in_ready=0; extra in_sum=77 with in_valid=1 ignored; map unchanged over 10 cycles.
//  3 from test 2, out_ready=1 one cycle -> out_valid=0, frame_cnt=1, in_ready=1 next cycle;
//    second frame of sums 10..18 delivered correctly.
//  4 sums -5,-1,0,3,-2048,2047,-7,8,-9 with in_valid toggled every other cycle -> with
//    CONV_OUT_RELU_EN: 0,0,0,3,0,2047,0,8,0; without: values unchanged (12-bit two's complement).
//  5 accept 4 sums, assert rst 1 cycle, then feed 9 sums 20..28 -> map = 20..28, out_row/out_col
//    restart at 0, frame_cnt=0 until handshake.
//  6 deliver 256 frames -> frame_cnt wraps to 0 after 256th out_ready handshake.

Source files
------------

// File: rtl/conv_out_collector.sv
// conv_out_collector
//   Downstream stage of the 3x3 window unit. Collects one signed window sum per
//   in_valid/in_ready handshake in raster order (row-major over output positions),
//   assembles a complete output feature map and presents it with an
//   out_valid/out_ready handshake. While a finished map is waiting to be taken,
//   in_ready is low so the window unit is held off.
//
//   Optional build macro: CONV_OUT_RELU_EN
//     defined   : negative sums are stored as zero (ReLU clamp)
//     undefined : sums are stored bit-exact, negatives kept
//   Handshake, timing and counters are identical in both builds.
//
// Ports
//   clk        in   1                    rising-edge clock
//   rst        in   1                    synchronous, active-high reset
//   in_valid   in   1                    in_sum carries a valid window sum
//   in_ready   out  1                    collector accepts in_sum this cycle (FILL)
//   in_sum     in   sum_width            signed window sum, two's complement
//   out_valid  out  1                    out_map holds a complete feature map
//   out_ready  in   1                    consumer takes out_map this cycle
//   out_map    out  out_size*sum_width   element k at [(k+1)*sum_width-1 : k*sum_width],
//                                        k = row*out_demension + col
//   out_row    out  8                    row index of next element to be written
//   out_col    out  8                    col index of next element to be written
//   frame_cnt  out  8                    maps delivered, wraps 255 -> 0
module conv_out_collector #(
  parameter int filter_demension = 3,
  parameter int stride           = 1,
  parameter int input_demension  = 5,
  parameter int sum_width        = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [sum_width-1:0]                   in_sum,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((input_demension-filter_demension)/stride+1)*
                ((input_demension-filter_demension)/stride+1)*sum_width-1:0] out_map,
  output logic [7:0]                             out_row,
  output logic [7:0]                             out_col,
  output logic [7:0]                             frame_cnt
);

  localparam int out_demension = (input_demension - filter_demension) / stride + 1;
  localparam int out_size      = out_demension * out_demension;
  localparam logic [7:0] LAST_IDX = 8'(out_demension - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                          state_q;
  logic [out_size*sum_width-1:0]   map_q;
  logic [7:0]                      row_q;
  logic [7:0]                      col_q;
  logic [7:0]                      frame_q;
  logic                            valid_q;

  logic [sum_width-1:0]            elem_d;
  logic [15:0]                     wr_idx;
  logic                            accept;
  logic                            last_elem;

`ifdef CONV_OUT_RELU_EN
  always_comb begin
    elem_d = in_sum[sum_width-1] ? '0 : in_sum;
  end
`else
  always_comb begin
    elem_d = in_sum;
  end
`endif

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign last_elem = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign wr_idx    = 16'(row_q) * 16'(out_demension) + 16'(col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      map_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            for (int unsigned k = 0; k < out_size; k++) begin
              if (k == 32'(wr_idx)) begin
                map_q[k*sum_width +: sum_width] <= elem_d;
              end
            end
            if (last_elem) begin
              row_q   <= '0;
              col_q   <= '0;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else if (col_q == LAST_IDX) begin
              col_q <= '0;
              row_q <= row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        HOLD: begin
          // Map and counters stay frozen until the consumer takes the map.
          if (out_ready) begin
            valid_q <= 1'b0;
            frame_q <= frame_q + 8'd1;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_map   = map_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector with 3x3 output, 12-bit sums.
module tb_conv_out_collector;

  localparam int SW = 12;
  localparam int OS = 9;
  localparam int MW = OS * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_sum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] out_map;
  logic [7:0]    out_row;
  logic [7:0]    out_col;
  logic [7:0]    frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [SW-1:0] exp_elem [OS];

  conv_out_collector #(
    .filter_demension(3),
    .stride(1),
    .input_demension(5),
    .sum_width(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_map(out_map),
    .out_row(out_row),
    .out_col(out_col),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] pack_exp();
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < OS; k++) m[k*SW +: SW] = exp_elem[k];
    return m;
  endfunction

  // Feeds nine consecutive sums base..base+8 back-to-back and records them as expected.
  task automatic feed_seq(input int base);
    for (int i = 0; i < OS; i++) begin
      in_valid = 1'b1;
      in_sum   = SW'(base + i);
      exp_elem[i] = SW'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    vectors++;
    if (out_map !== '0) begin miscompares++; $display("FAIL reset_map: got %0h expected 0", out_map); end
    vectors++;
    if (out_row !== 8'd0 || out_col !== 8'd0) begin
      miscompares++; $display("FAIL reset_rowcol: got %0d/%0d expected 0/0", out_row, out_col);
    end
    vectors++;
    if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_fill_hold();
    for (int i = 0; i < OS; i++) begin
      in_valid = 1'b1;
      in_sum   = SW'(i + 1);
      exp_elem[i] = SW'(i + 1);
      tick();
      if (i < OS - 1) begin
        vectors++;
        if (out_row !== 8'((i + 1) / 3) || out_col !== 8'((i + 1) % 3) || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_progress[%0d]: got row=%0d col=%0d valid=%0b expected row=%0d col=%0d valid=0",
                   i, out_row, out_col, out_valid, (i + 1) / 3, (i + 1) % 3);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid_latency: got %0b expected 1", out_valid); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready: got %0b expected 0", in_ready); end
    vectors++;
    if (out_map !== pack_exp()) begin
      miscompares++; $display("FAIL fill_map: got %0h expected %0h", out_map, pack_exp());
    end
    vectors++;
    if (out_row !== 8'd0 || out_col !== 8'd0) begin
      miscompares++; $display("FAIL fill_wrap_rowcol: got %0d/%0d expected 0/0", out_row, out_col);
    end
    in_valid = 1'b1;
    in_sum   = SW'(77);
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (out_map !== pack_exp() || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_row !== 8'd0 || out_col !== 8'd0) begin
        miscompares++;
        $display("FAIL hold_frozen[%0d]: got valid=%0b ready=%0b row=%0d col=%0d map=%0h expected valid=1 ready=0 row=0 col=0 map=%0h",
                 c, out_valid, in_ready, out_row, out_col, out_map, pack_exp());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_release_second();
    in_valid  = 1'b1;
    in_sum    = SW'(55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || frame_cnt !== 8'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: got valid=%0b frame=%0d ready=%0b expected valid=0 frame=1 ready=1",
               out_valid, frame_cnt, in_ready);
    end
    vectors++;
    if (out_row !== 8'd0 || out_col !== 8'd0) begin
      miscompares++; $display("FAIL release_rowcol: got %0d/%0d expected 0/0", out_row, out_col);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (frame_cnt !== 8'd1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL ready_idle: got frame=%0d valid=%0b expected 1/0", frame_cnt, out_valid);
    end
    feed_seq(10);
    vectors++;
    if (out_valid !== 1'b1 || out_map !== pack_exp()) begin
      miscompares++;
      $display("FAIL second_frame: got valid=%0b map=%0h expected valid=1 map=%0h", out_valid, out_map, pack_exp());
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (frame_cnt !== 8'd2 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL second_release: got frame=%0d valid=%0b expected 2/0", frame_cnt, out_valid);
    end
  endtask

  task automatic test_signed_gaps();
    logic [SW-1:0] raw [OS];
    logic [SW-1:0] relu [OS];
    raw  = '{12'hFFB, 12'hFFF, 12'h000, 12'h003, 12'h800, 12'h7FF, 12'hFF9, 12'h008, 12'hFF7};
    relu = '{12'h000, 12'h000, 12'h000, 12'h003, 12'h000, 12'h7FF, 12'h000, 12'h008, 12'h000};
    for (int i = 0; i < OS; i++) begin
`ifdef CONV_OUT_RELU_EN
      exp_elem[i] = relu[i];
`else
      exp_elem[i] = raw[i];
`endif
      in_valid = 1'b0;
      in_sum   = 12'h555;
      tick();
      vectors++;
      if (out_row !== 8'(i / 3) || out_col !== 8'(i % 3)) begin
        miscompares++;
        $display("FAIL gap_hold[%0d]: got %0d/%0d expected %0d/%0d", i, out_row, out_col, i / 3, i % 3);
      end
      in_valid = 1'b1;
      in_sum   = raw[i];
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_map !== pack_exp()) begin
      miscompares++;
      $display("FAIL signed_map: got valid=%0b map=%0h expected valid=1 map=%0h", out_valid, out_map, pack_exp());
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (frame_cnt !== 8'd3) begin miscompares++; $display("FAIL signed_frame: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = SW'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_row !== 8'd1 || out_col !== 8'd1) begin
      miscompares++; $display("FAIL partial_rowcol: got %0d/%0d expected 1/1", out_row, out_col);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_row !== 8'd0 || out_col !== 8'd0 || frame_cnt !== 8'd0 || out_map !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: got row=%0d col=%0d frame=%0d valid=%0b map=%0h expected all 0",
               out_row, out_col, frame_cnt, out_valid, out_map);
    end
    feed_seq(20);
    vectors++;
    if (out_valid !== 1'b1 || out_map !== pack_exp() || frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL post_reset_frame: got valid=%0b frame=%0d map=%0h expected valid=1 frame=0 map=%0h",
               out_valid, frame_cnt, out_map, pack_exp());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_map !== '0) begin
      miscompares++;
      $display("FAIL hold_reset: got valid=%0b ready=%0b map=%0h expected 0/1/0", out_valid, in_ready, out_map);
    end
  endtask

  task automatic test_frame_wrap();
    for (int f = 0; f < 256; f++) begin
      feed_seq(f);
      if (out_valid !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL wrap_valid[%0d]: got %0b expected 1", f, out_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (f == 254) begin
        vectors++;
        if (frame_cnt !== 8'd255) begin miscompares++; $display("FAIL frame_255: got %0d expected 255", frame_cnt); end
      end
    end
    vectors++;
    if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL frame_wrap: got %0d expected 0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill_hold();
    test_release_second();
    test_signed_gaps();
    test_reset_midframe();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
